// File: rtl/fifo_xfer_pkg.sv
// Shared word-layout and state definitions for the event sample FIFO.
// The load FSM and the unload FSM both import this package so that both ends
// agree on the number of words per sample and on the counter widths.
package fifo_xfer_pkg;

  // Unload controller states; the encoding is fixed so that the three
  // redundant copies can be compared bit by bit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } xfer_state_e;

  localparam int NWORDS_DEF = 6;   // words per sample
  localparam int SAMP_W_DEF = 7;   // sample counter width
  localparam int CNT_W_DEF  = 16;  // SEU error counter width
  localparam int SEL_W      = 3;   // word index width

endpackage

// File: rtl/fifo_unload_fsm_tmr_vote.sv
// Bitwise 2-of-3 majority voter for one triplicated register group.
// mismatch flags any bit position where the three copies are not unanimous.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] voted,
  output logic         mismatch
);

  assign voted    = (a & b) | (a & c) | (b & c);
  assign mismatch = |((a ^ b) | (a ^ c));

endmodule

// File: rtl/fifo_unload_fsm_tmr.sv
// Read-side controller for the per-event sample FIFO.
// Drains NWORDS words per sample for samples 0..SAMP_MAX under FIFO-empty and
// downstream back-pressure, tagging each delivered word with SEL, SAMPLE and
// LAST. Every control register is held in three copies; all next-value logic
// works on voted values and any copy disagreement bumps a saturating counter.
module fifo_unload_fsm_tmr
  import fifo_xfer_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int SAMP_W = SAMP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [SAMP_W-1:0] SAMP_MAX,
  input  logic              START,
  input  logic              FIFO_EMPTY,
  input  logic              DS_READY,
  output logic              RDENA,
  output logic [SEL_W-1:0]  SEL,
  output logic [SAMP_W-1:0] SAMPLE,
  output logic              DVALID,
  output logic              LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  TMR_ERR_COUNT
);

  localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(NWORDS - 1);
  localparam logic [SEL_W-1:0]  SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0]  SEL_ZERO = SEL_W'(0);
  localparam logic [SAMP_W-1:0] SAMP_ONE = SAMP_W'(1);
  localparam logic [SAMP_W-1:0] SAMP_ZRO = SAMP_W'(0);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};
  localparam int CTR_W = SEL_W + 2 * SAMP_W;      // {rsel, rsamp, smax}
  localparam int OUT_W = SEL_W + SAMP_W + 3;      // {sel, sample, dvalid, last, done}

  // Three copies of every register group
  logic [1:0]       state_q0, state_q1, state_q2;
  logic [CTR_W-1:0] ctr_q0, ctr_q1, ctr_q2;
  logic [OUT_W-1:0] out_q0, out_q1, out_q2;
  logic [CNT_W-1:0] cnt_q0, cnt_q1, cnt_q2;

  // Voted views and disagreement flags
  logic [1:0]       state_vote_s;
  logic [CTR_W-1:0] ctr_vote_s;
  logic [OUT_W-1:0] out_vote_s;
  logic [CNT_W-1:0] cnt_vote_s;
  logic             mm_state_s, mm_ctr_s, mm_out_s, mm_cnt_s;
  logic             err_s;

  xfer_state_e       state_v, state_d;
  logic [SEL_W-1:0]  rsel_v, rsel_d, rsel_eff_s;
  logic [SAMP_W-1:0] rsamp_v, rsamp_d;
  logic [SAMP_W-1:0] smax_v, smax_d;
  logic [SEL_W-1:0]  sel_v, sel_d;
  logic [SAMP_W-1:0] samp_v, samp_d;
  logic              dvalid_v, dvalid_d;
  logic              last_v, last_d;
  logic              done_v, done_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              rdena_s, term_s;
  logic [CTR_W-1:0]  ctr_d;
  logic [OUT_W-1:0]  out_d;

  tmr_vote #(.W(2)) u_vote_state (
    .a(state_q0), .b(state_q1), .c(state_q2), .voted(state_vote_s), .mismatch(mm_state_s)
  );
  tmr_vote #(.W(CTR_W)) u_vote_ctr (
    .a(ctr_q0), .b(ctr_q1), .c(ctr_q2), .voted(ctr_vote_s), .mismatch(mm_ctr_s)
  );
  tmr_vote #(.W(OUT_W)) u_vote_out (
    .a(out_q0), .b(out_q1), .c(out_q2), .voted(out_vote_s), .mismatch(mm_out_s)
  );
  tmr_vote #(.W(CNT_W)) u_vote_cnt (
    .a(cnt_q0), .b(cnt_q1), .c(cnt_q2), .voted(cnt_vote_s), .mismatch(mm_cnt_s)
  );

  assign state_v = xfer_state_e'(state_vote_s);
  assign {rsel_v, rsamp_v, smax_v} = ctr_vote_s;
  assign {sel_v, samp_v, dvalid_v, last_v, done_v} = out_vote_s;
  assign err_s = mm_state_s | mm_ctr_s | mm_out_s | mm_cnt_s;
  assign ctr_d = {rsel_d, rsamp_d, smax_d};
  assign out_d = {sel_d, samp_d, dvalid_d, last_d, done_d};

  // Read qualification: an out-of-range word index is clamped to the last word
  // so a corrupted counter still wraps on the next read.
  always_comb begin
    if (rsel_v > LAST_SEL) begin
      rsel_eff_s = LAST_SEL;
    end else begin
      rsel_eff_s = rsel_v;
    end
    rdena_s = (state_v == ST_READ) && !FIFO_EMPTY && DS_READY;
    term_s  = (rsamp_v == smax_v) && (rsel_eff_s == LAST_SEL);
  end

  // State register: all three copies load the same voted next value
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q0 <= 2'b00;
      state_q1 <= 2'b00;
      state_q2 <= 2'b00;
      ctr_q0   <= {CTR_W{1'b0}};
      ctr_q1   <= {CTR_W{1'b0}};
      ctr_q2   <= {CTR_W{1'b0}};
      out_q0   <= {OUT_W{1'b0}};
      out_q1   <= {OUT_W{1'b0}};
      out_q2   <= {OUT_W{1'b0}};
      cnt_q0   <= {CNT_W{1'b0}};
      cnt_q1   <= {CNT_W{1'b0}};
      cnt_q2   <= {CNT_W{1'b0}};
    end else begin
      state_q0 <= state_d;
      state_q1 <= state_d;
      state_q2 <= state_d;
      ctr_q0   <= ctr_d;
      ctr_q1   <= ctr_d;
      ctr_q2   <= ctr_d;
      out_q0   <= out_d;
      out_q1   <= out_d;
      out_q2   <= out_d;
      cnt_q0   <= cnt_d;
      cnt_q1   <= cnt_d;
      cnt_q2   <= cnt_d;
    end
  end

  // Next state and read counters; START is only honoured in Idle
  always_comb begin
    state_d = state_v;
    rsel_d  = rsel_v;
    rsamp_d = rsamp_v;
    smax_d  = smax_v;
    case (state_v)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_READ;
          rsel_d  = SEL_ZERO;
          rsamp_d = SAMP_ZRO;
          smax_d  = SAMP_MAX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rdena_s) begin
          if (rsel_eff_s == LAST_SEL) begin
            rsel_d = SEL_ZERO;
            if (term_s) begin
              // final word: stop here so rsamp never wraps past smax
              state_d = ST_DRAIN;
              rsamp_d = rsamp_v;
            end else begin
              state_d = ST_READ;
              rsamp_d = rsamp_v + SAMP_ONE;
            end
          end else begin
            state_d = ST_READ;
            rsel_d  = rsel_eff_s + SEL_ONE;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output pipeline next values: data tags follow RDENA by one cycle
  always_comb begin
    dvalid_d = rdena_s;
    last_d   = rdena_s & term_s;
    done_d   = (state_d == ST_DONE);
    if (rdena_s) begin
      sel_d  = rsel_eff_s;
      samp_d = rsamp_v;
    end else begin
      sel_d  = sel_v;
      samp_d = samp_v;
    end
  end

  // SEU counter next value: one step per cycle with any copy disagreement
  always_comb begin
    if (cnt_vote_s == CNT_SAT) begin
      cnt_d = cnt_vote_s;
    end else if (err_s) begin
      cnt_d = cnt_vote_s + CNT_W'(1);
    end else begin
      cnt_d = cnt_vote_s;
    end
  end

  assign RDENA         = rdena_s;
  assign SEL           = sel_v;
  assign SAMPLE        = samp_v;
  assign DVALID        = dvalid_v;
  assign LAST          = last_v;
  assign DONE          = done_v;
  assign BUSY          = (state_v != ST_IDLE);
  assign TMR_ERR_COUNT = cnt_vote_s;

endmodule

// File: tb/tb_fifo_unload_fsm_tmr.sv
// Directed bench for fifo_unload_fsm_tmr: a cycle table for a short event
// with back-pressure and ignored STARTs, plus scoreboarded full events,
// redundancy-fault injection and mid-event reset.
module tb_fifo_unload_fsm_tmr;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [6:0]  SAMP_MAX = 7'd0;
  logic        START = 1'b0;
  logic        FIFO_EMPTY = 1'b0;
  logic        DS_READY = 1'b0;
  logic        RDENA;
  logic [2:0]  SEL;
  logic [6:0]  SAMPLE;
  logic        DVALID, LAST, BUSY, DONE;
  logic [15:0] TMR_ERR_COUNT;

  int total_n = 0;
  int bad_n   = 0;

  fifo_unload_fsm_tmr dut (
    .CLK(CLK), .RST(RST), .SAMP_MAX(SAMP_MAX), .START(START),
    .FIFO_EMPTY(FIFO_EMPTY), .DS_READY(DS_READY), .RDENA(RDENA),
    .SEL(SEL), .SAMPLE(SAMPLE), .DVALID(DVALID), .LAST(LAST),
    .BUSY(BUSY), .DONE(DONE), .TMR_ERR_COUNT(TMR_ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       st, fe, dr;
    logic       rd, dv;
    logic [2:0] sel;
    logic [6:0] samp;
    logic       last, busy, done;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(input logic st, input logic fe, input logic dr,
                              input logic rd, input logic dv, input logic [2:0] sel,
                              input logic [6:0] samp, input logic last,
                              input logic busy, input logic done);
    vec_t v;
    v.st = st; v.fe = fe; v.dr = dr; v.rd = rd; v.dv = dv;
    v.sel = sel; v.samp = samp; v.last = last; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge; return at the following falling edge.
  task automatic drive(input logic st, input logic fe, input logic dr);
    @(posedge CLK);
    #1;
    START = st; FIFO_EMPTY = fe; DS_READY = dr;
    @(negedge CLK);
  endtask

  // One event with a scoreboard on word order, LAST, RDENA and DONE timing.
  // mode 0: free flow; 1: DS_READY toggles; 2: FIFO empty for 4 cycles after 7 reads.
  task automatic run_event(input logic [6:0] smax, input int mode, input bit do_start);
    int total, issued, got, cyc, stall, last_rd, done_at, budget;
    logic fe, dr, exp_rd;
    logic [2:0] esel;
    logic [6:0] esamp;
    total = (int'(smax) + 1) * 6;
    issued = 0; got = 0; cyc = 0; stall = 0; last_rd = -100; done_at = -1;
    esel = 3'd0; esamp = 7'd0;
    budget = 4 * total + 40;
    SAMP_MAX = smax;
    if (do_start) drive(1'b1, 1'b0, 1'b1);
    while (done_at < 0 && cyc < budget) begin
      cyc++;
      fe = 1'b0;
      dr = 1'b1;
      if (mode == 1) dr = (cyc % 2 == 1);
      if (mode == 2 && issued == 7 && stall < 4) begin
        fe = 1'b1;
        stall++;
      end
      drive(1'b0, fe, dr);
      exp_rd = (issued < total) && !fe && dr;
      chk("rdena", 32'(RDENA), 32'(exp_rd));
      chk("busy", 32'(BUSY), 32'd1);
      if (DVALID) begin
        chk("word_sel", 32'(SEL), 32'(esel));
        chk("word_sample", 32'(SAMPLE), 32'(esamp));
        chk("word_last", 32'(LAST), 32'((esamp == smax) && (esel == 3'd5)));
        got++;
        if (esel == 3'd5) begin
          esel = 3'd0;
          esamp = esamp + 7'd1;
        end else begin
          esel = esel + 3'd1;
        end
      end else begin
        chk("last_without_dvalid", 32'(LAST), 32'd0);
      end
      if (RDENA) begin
        issued++;
        last_rd = cyc;
      end
      if (DONE) done_at = cyc;
    end
    chk("word_count", 32'(got), 32'(total));
    chk("done_seen", 32'(done_at >= 0), 32'd1);
    chk("done_latency", 32'(done_at - last_rd), 32'd2);
    drive(1'b0, 1'b0, 1'b1);
    chk("idle_after_done", 32'({BUSY, DONE}), 32'd0);
  endtask

  initial begin
    // short event, SAMP_MAX=0, with stalls and STARTs that must be ignored
    vt[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[6]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 7'd0, 1'b0, 1'b1, 1'b0);
    vt[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 7'd0, 1'b1, 1'b1, 1'b0);
    vt[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 7'd0, 1'b0, 1'b1, 1'b1);
    vt[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 7'd0, 1'b0, 1'b0, 1'b0);

    // reset state
    repeat (2) @(negedge CLK);
    chk("reset_outputs", 32'({RDENA, DVALID, SEL, SAMPLE, LAST, BUSY, DONE, TMR_ERR_COUNT}), 32'd0);
    RST = 1'b0;

    // cycle table
    SAMP_MAX = 7'd0;
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].st, vt[i].fe, vt[i].dr);
      chk($sformatf("vec%0d", i),
          32'({RDENA, DVALID, SEL, SAMPLE, LAST, BUSY, DONE}),
          32'({vt[i].rd, vt[i].dv, vt[i].sel, vt[i].samp, vt[i].last, vt[i].busy, vt[i].done}));
    end

    // full events: free flow, back-pressure, FIFO empty window, max sample index
    run_event(7'd2, 0, 1'b1);
    run_event(7'd2, 1, 1'b1);
    run_event(7'd2, 2, 1'b1);
    run_event(7'd127, 0, 1'b1);

    // redundancy fault on one state copy while stalled in Read
    SAMP_MAX = 7'd0;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t5_err_base", 32'(TMR_ERR_COUNT), 32'd0);
    force dut.state_q2 = 2'b10;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("t5_err_count3", 32'(TMR_ERR_COUNT), 32'd3);
    chk("t5_outputs_unaffected", 32'({RDENA, DVALID, BUSY, DONE}), 32'b0010);
    release dut.state_q2;
    drive(1'b0, 1'b0, 1'b0);
    force dut.cnt_q0 = 16'hFFFE;
    force dut.cnt_q1 = 16'hFFFE;
    force dut.cnt_q2 = 16'hFFFE;
    drive(1'b0, 1'b0, 1'b0);
    release dut.cnt_q0;
    release dut.cnt_q1;
    release dut.cnt_q2;
    drive(1'b0, 1'b0, 1'b0);
    chk("t5_preload", 32'(TMR_ERR_COUNT), 32'h0000FFFE);
    force dut.state_q2 = 2'b10;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("t5_saturate", 32'(TMR_ERR_COUNT), 32'h0000FFFF);
    release dut.state_q2;
    drive(1'b0, 1'b0, 1'b0);
    run_event(7'd0, 0, 1'b0);

    // reset during word 9, then a clean event from the start
    SAMP_MAX = 7'd2;
    drive(1'b1, 1'b0, 1'b1);
    repeat (8) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("t6_word9_reading", 32'({RDENA, SEL, SAMPLE}), 32'({1'b1, 3'd1, 7'd1}));
    chk("t6_cnt_before_rst", 32'(TMR_ERR_COUNT), 32'h0000FFFF);
    RST = 1'b1;
    #1;
    chk("t6_rst_outputs", 32'({RDENA, DVALID, SEL, SAMPLE, LAST, BUSY, DONE}), 32'd0);
    chk("t6_rst_count", 32'(TMR_ERR_COUNT), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    run_event(7'd2, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
